utopia_phy_tx: RTL and testbench

- PHY-side Utopia Level-1 cell source. It drives data, soc and clav into the ATM-layer receive port (CoreReceive) and responds to en.
- Cells are loaded byte-wise from a local stream, buffered in a 2-cell FIFO, and released only as whole cells under cell-level handshake.
- Serves as the synthesizable counterpart of the receive core, for loopback and emulation.

---
 rtl/utopia_phy_tx_if.sv | 25 ++
 rtl/utopia_phy_tx.sv | 151 +++++++++++++++
 tb/tb_utopia_phy_tx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/utopia_phy_tx_if.sv
// Signal bundle between the Utopia Level-1 PHY cell source and its neighbours:
// the byte-wise load stream plus the Utopia receive-port signals.
interface utopia_phy_tx_if #(
   parameter int IfWidth = 8
);
   logic               in_valid;
   logic               in_sop;
   logic [IfWidth-1:0] in_data;
   logic               in_ready;
   logic               en;
   logic               clav;
   logic               soc;
   logic [IfWidth-1:0] data;
   logic               err_sop;

   modport master (
      output in_valid, in_sop, in_data, en,
      input  in_ready, clav, soc, data, err_sop
   );

   modport slave (
      input  in_valid, in_sop, in_data, en,
      output in_ready, clav, soc, data, err_sop
   );
endinterface

// File: rtl/utopia_phy_tx.sv
// Utopia Level-1 PHY-side cell source: buffers whole cells loaded byte-wise
// and releases them to the ATM layer under the clav/en cell handshake.
module utopia_phy_tx #(
   parameter int IfWidth    = 8,
   parameter int CellBytes  = 53,
   parameter int DepthCells = 2
) (
   input logic             clk_in,
   input logic             reset,
   utopia_phy_tx_if.slave  bus
);
   localparam int Total = DepthCells * CellBytes;
   localparam int PtrW  = (Total > 1) ? $clog2(Total) : 1;
   localparam int ByteW = $clog2(CellBytes + 1);
   localparam int CntW  = $clog2(DepthCells + 1);

   localparam logic [PtrW-1:0]  PtrLast  = PtrW'(Total - 1);
   localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
   localparam logic [ByteW-1:0] ByteLast = ByteW'(CellBytes - 1);
   localparam logic [ByteW-1:0] ByteOne  = ByteW'(1);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);
   localparam logic [CntW-1:0]  DepthCnt = CntW'(DepthCells);

   typedef enum logic [1:0] {IDLE, SEND, LAST} tx_state_t;

   logic [IfWidth-1:0] mem [Total];

   logic [PtrW-1:0]    wr_ptr, wr_base, wr_addr, rd_ptr;
   logic [ByteW-1:0]   wr_byte, wr_idx, tx_byte;
   logic               wr_open;
   logic [CntW-1:0]    full_cells, slots_used;
   logic               accept, wr_en, wr_first, wr_restart, wr_drop, wr_done;
   logic               tx_start, tx_adv, tx_done;
   logic [IfWidth-1:0] data_q;
   logic               soc_q, err_q;
   tx_state_t          state_q, state_d;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + PtrOne;
   endfunction

   // An open cell may always finish; only a new slot needs free room.
   assign bus.in_ready = (slots_used < DepthCnt) || wr_open;
   assign bus.clav     = (full_cells != '0);
   assign bus.data     = data_q;
   assign bus.soc      = soc_q;
   assign bus.err_sop  = err_q;

   assign accept     = bus.in_valid && bus.in_ready;
   assign wr_first   = accept && bus.in_sop && !wr_open;
   assign wr_restart = accept && bus.in_sop && wr_open;
   assign wr_drop    = accept && !bus.in_sop && !wr_open;
   assign wr_en      = accept && (bus.in_sop || wr_open);
   assign wr_addr    = wr_restart ? wr_base : wr_ptr;
   assign wr_idx     = wr_restart ? '0 : wr_byte;
   assign wr_done    = wr_en && (wr_idx == ByteLast);

   // NOTE: the byte RAM has no reset; the pointers and counters alone define what is valid.
   always_ff @(posedge clk_in) begin
      if (wr_en) mem[wr_addr] <= bus.in_data;
   end

   // NOTE: every clocked register uses non-blocking assignment so all of them update together.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr  <= '0;
         wr_base <= '0;
         wr_byte <= '0;
         wr_open <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= wr_drop || wr_restart;
         if (wr_en) begin
            wr_ptr <= next_ptr(wr_addr);
            if (wr_first) wr_base <= wr_ptr;
            if (wr_done) begin
               wr_open <= 1'b0;
               wr_byte <= '0;
            end else begin
               wr_open <= 1'b1;
               wr_byte <= wr_idx + ByteOne;
            end
         end
      end
   end

   // Completion and read start on the same edge cancel out.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         full_cells <= '0;
         slots_used <= '0;
      end else begin
         case ({wr_done, tx_start})
            2'b10:   full_cells <= full_cells + CntOne;
            2'b01:   full_cells <= full_cells - CntOne;
            default: ;
         endcase
         case ({wr_first, tx_done})
            2'b10:   slots_used <= slots_used + CntOne;
            2'b01:   slots_used <= slots_used - CntOne;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: combinational blocks assign a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, LAST: state_d = tx_start ? SEND : IDLE;
         SEND:       state_d = tx_done ? LAST : SEND;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_start = 1'b0;
      tx_adv   = 1'b0;
      tx_done  = 1'b0;
      case (state_q)
         IDLE, LAST: tx_start = !bus.en && (full_cells != '0);
         SEND: begin
            tx_adv  = !bus.en;
            tx_done = !bus.en && (tx_byte == ByteLast);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         rd_ptr  <= '0;
         tx_byte <= '0;
         data_q  <= '0;
         soc_q   <= 1'b0;
      end else begin
         soc_q <= tx_start;
         if (tx_start || tx_adv) begin
            data_q <= mem[rd_ptr];
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (tx_start)    tx_byte <= ByteOne;
         else if (tx_adv) tx_byte <= tx_byte + ByteOne;
      end
   end
endmodule

// File: tb/tb_utopia_phy_tx.sv
// Self-checking bench for utopia_phy_tx: framing vector table, cell loads feeding
// a byte scoreboard, and a protocol monitor that predicts every output byte.
module tb_utopia_phy_tx;
   localparam int CellBytes = 53;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   always #5 clk_in = ~clk_in;

   utopia_phy_tx_if #(.IfWidth(8)) bus ();

   utopia_phy_tx #(.IfWidth(8), .CellBytes(CellBytes), .DepthCells(2)) dut (
      .clk_in (clk_in),
      .reset  (reset),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int err_cnt  = 0;
   int mon_cnt  = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] sb [$];

   typedef struct {
      string      name;
      logic       valid;
      logic       sop;
      logic [7:0] din;
      logic       exp_ready;
      logic       exp_err;
      logic       exp_clav;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: predicts each edge's data/soc from en, clav and the scoreboard.
   always begin
      logic en_s, clav_s, rst_s;
      logic [7:0] exp_b;
      @(posedge clk_in);
      en_s = bus.en; clav_s = bus.clav; rst_s = reset;
      #1;
      if (bus.err_sop) err_cnt++;
      if (rst_s) begin
         check("rst_data", {24'h0, bus.data}, 32'h0);
         check("rst_soc",  {31'h0, bus.soc},  32'h0);
         check("rst_clav", {31'h0, bus.clav}, 32'h0);
         sb.delete();
         mon_cnt   = 0;
         last_data = 8'h00;
      end else if (!en_s && (mon_cnt > 0 || clav_s)) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'h1, 32'h0);
         end else begin
            exp_b = sb.pop_front();
            check("tx_data", {24'h0, bus.data}, {24'h0, exp_b});
            check("tx_soc", {31'h0, bus.soc}, {31'h0, (mon_cnt == 0)});
            last_data = exp_b;
         end
         mon_cnt = (mon_cnt == CellBytes - 1) ? 0 : mon_cnt + 1;
      end else begin
         check("hold_data", {24'h0, bus.data}, {24'h0, last_data});
         check("hold_soc", {31'h0, bus.soc}, 32'h0);
      end
   end

   task automatic do_reset();
      @(negedge clk_in);
      reset = 1'b1; bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.en = 1'b1;
      @(negedge clk_in);
      reset = 1'b0;
      check("post_rst_ready", {31'h0, bus.in_ready}, 32'h1);
      check("post_rst_data", {24'h0, bus.data}, 32'h0);
      check("post_rst_clav", {31'h0, bus.clav}, 32'h0);
   endtask

   task automatic put_byte(input logic [7:0] b, input logic sop);
      int waitc = 0;
      @(negedge clk_in);
      bus.in_valid = 1'b1; bus.in_sop = sop; bus.in_data = b;
      while (!bus.in_ready && waitc < 1000) begin
         @(negedge clk_in);
         waitc++;
      end
      if (!bus.in_ready) check("load_timeout", 32'h1, 32'h0);
      @(posedge clk_in);
   endtask

   task automatic load_cell(input logic [7:0] base);
      for (int i = 0; i < CellBytes; i++) put_byte(base + 8'(i), (i == 0));
      for (int i = 0; i < CellBytes; i++) sb.push_back(base + 8'(i));
   endtask

   task automatic idle_load();
      @(negedge clk_in);
      bus.in_valid = 1'b0; bus.in_sop = 1'b0;
   endtask

   task automatic drain(input string name);
      int c = 0;
      while ((sb.size() != 0 || mon_cnt != 0) && c < 2000) begin
         @(negedge clk_in);
         c++;
      end
      check(name, sb.size(), 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int e0, waitc;
      vecs[0] = '{"v_idle",  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{"v_stray", 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{"v_idle2", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{"v_open",  1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{"v_body",  1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{"v_resop", 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{"v_idle3", 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_data = 8'h00; bus.en = 1'b1;
      do_reset();

      // Framing vectors on the load side.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_in);
         bus.in_valid = vecs[i].valid; bus.in_sop = vecs[i].sop; bus.in_data = vecs[i].din;
         @(posedge clk_in); #1;
         check({vecs[i].name, "_ready"}, {31'h0, bus.in_ready}, {31'h0, vecs[i].exp_ready});
         check({vecs[i].name, "_err"},   {31'h0, bus.err_sop},  {31'h0, vecs[i].exp_err});
         check({vecs[i].name, "_clav"},  {31'h0, bus.clav},     {31'h0, vecs[i].exp_clav});
      end
      do_reset();

      // One cell 0x00..0x34, then stream it out with en held low.
      load_cell(8'h00);
      idle_load();
      check("t1_clav_up", {31'h0, bus.clav}, 32'h1);
      bus.en = 1'b0;
      @(posedge clk_in); #1;
      check("t1_clav_drop", {31'h0, bus.clav}, 32'h0);
      check("t1_first_soc", {31'h0, bus.soc}, 32'h1);
      drain("t1_drain");
      @(negedge clk_in); bus.en = 1'b1;

      // Two cells fill the buffer; a third stalls until the first has gone.
      load_cell(8'h35);
      load_cell(8'h6A);
      idle_load();
      check("t2_full_ready", {31'h0, bus.in_ready}, 32'h0);
      check("t2_full_clav", {31'h0, bus.clav}, 32'h1);
      fork
         load_cell(8'h9F);
         begin
            repeat (4) @(negedge clk_in);
            check("t2_stall_ready", {31'h0, bus.in_ready}, 32'h0);
            bus.en = 1'b0;
         end
      join
      idle_load();
      drain("t2_drain");
      @(negedge clk_in); bus.en = 1'b1;

      // en toggling every edge during one cell.
      load_cell(8'hA0);
      idle_load();
      for (int i = 0; i < 2 * CellBytes + 4; i++) begin
         @(negedge clk_in);
         bus.en = (i % 2 == 0) ? 1'b0 : 1'b1;
      end
      bus.en = 1'b1;
      drain("t4_drain");

      // Partial cell restarted by in_sop at byte 20.
      e0 = err_cnt;
      for (int i = 0; i < 20; i++) put_byte(8'hC0 + 8'(i), (i == 0));
      load_cell(8'h80);
      idle_load();
      @(negedge clk_in);
      check("t5_err_pulses", err_cnt - e0, 32'h1);
      check("t5_clav", {31'h0, bus.clav}, 32'h1);
      bus.en = 1'b0;
      drain("t5_drain");
      @(negedge clk_in); bus.en = 1'b1;

      // Reset while byte 30 of a cell is on the bus.
      load_cell(8'h10);
      idle_load();
      bus.en = 1'b0;
      waitc = 0;
      while (mon_cnt != 30 && waitc < 200) begin
         @(negedge clk_in);
         waitc++;
      end
      check("t6_reach_30", mon_cnt, 32'd30);
      do_reset();
      check("t6_soc", {31'h0, bus.soc}, 32'h0);
      bus.en = 1'b0;
      repeat (5) @(negedge clk_in);
      check("t6_idle_clav", {31'h0, bus.clav}, 32'h0);
      load_cell(8'h60);
      idle_load();
      drain("t6_drain");

      @(negedge clk_in);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
